// File: rtl/nl_xbar_allocator.sv
// Per-output round-robin wormhole allocator for an n x n crossbar.
// Each output locks to one input from head to tail flit; select is registered, grant is combinational.
module nl_xbar_allocator #(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [n-1:0][n-1:0] req,
  input  logic [n-1:0]        tail,
  input  logic [n-1:0]        out_ready,
  output logic [n-1:0][n-1:0] select,
  output logic [n-1:0]        grant
);
  localparam int w = $clog2(n);
  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic [n-1:0]          locked, locked_d;
  logic [n-1:0][w-1:0]   owner, owner_d;
  logic [n-1:0][w-1:0]   ptr, ptr_d;
  logic [n-1:0][n-1:0]   select_d;
  logic [n-1:0]          rel;
  logic [n-1:0][n-1:0]   busy_elsewhere;  // [o][i]: input i holds a lock on some output other than o

  // A flit crosses when the owner still requests and the output can take it.
  always_comb begin
    grant = '0;
    rel   = '0;
    for (int o = 0; o < n; o++) begin
      for (int i = 0; i < n; i++) begin
        if (locked[o] == LOCKED && owner[o] == w'(i) && req[i][o] && out_ready[o]) begin
          grant[i] = 1'b1;
          rel[o]   = tail[i];
        end
      end
    end
  end

  always_comb begin
    busy_elsewhere = '0;
    for (int o = 0; o < n; o++) begin
      for (int p = 0; p < n; p++) begin
        if (p != o && locked[p] == LOCKED) busy_elsewhere[o][owner[p]] = 1'b1;
      end
    end
  end

  // Arbitration runs on idle outputs and on outputs releasing this cycle; the
  // releasing owner sits last in the scan because ptr has moved past it.
  always_comb begin
    int   start;
    int   idx;
    logic found;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    locked_d = locked;
    owner_d  = owner;
    ptr_d    = ptr;
    select_d = '0;
    start    = 0;
    idx      = 0;
    found    = 1'b0;
    for (int o = 0; o < n; o++) begin
      if (locked[o] == IDLE || rel[o]) begin
        start       = rel[o] ? (int'(owner[o]) + 1) % n : int'(ptr[o]);
        ptr_d[o]    = w'(start);
        locked_d[o] = IDLE;
        // NOTE: blocking assignments in combinational logic so 'found' is seen by later iterations.
        found       = 1'b0;
        for (int k = 0; k < n; k++) begin
          idx = (start + k) % n;
          if (!found && req[idx][o] && !busy_elsewhere[o][idx]) begin
            found       = 1'b1;
            locked_d[o] = LOCKED;
            owner_d[o]  = w'(idx);
          end
        end
      end
      if (locked_d[o] == LOCKED) select_d[o][owner_d[o]] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; all state is small and fully reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= '0;
      owner  <= '0;
      ptr    <= '0;
      select <= '0;
    end else begin
      locked <= locked_d;
      owner  <= owner_d;
      ptr    <= ptr_d;
      select <= select_d;
    end
  end

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < n; gi++) begin : g_req_chk
    a_req_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req[gi]));
  end
  for (genvar go = 0; go < n; go++) begin : g_own_chk
    a_owner_holds: assert property (@(posedge clk) disable iff (rst)
      locked[go] |-> req[owner[go]][go]);
  end
`endif
endmodule

// File: tb/tb_nl_xbar_allocator.sv
// Self-checking bench for nl_xbar_allocator (n=4): directed vector table, reset corner
// cases, and a constrained-random phase checking grant, wormhole integrity and fairness.
module tb_nl_xbar_allocator;
  localparam int n = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [n-1:0][n-1:0] req;
  logic [n-1:0]        tail;
  logic [n-1:0]        out_ready;
  logic [n-1:0][n-1:0] select;
  logic [n-1:0]        grant;

  int checks = 0;
  int passed = 0;

  nl_xbar_allocator #(.n(n)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [15:0] req;
    logic [3:0]  tail;
    logic [3:0]  rdy;
    logic [15:0] sel;
    logic [3:0]  grant;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] sel;
    logic [3:0]  grant;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic rf, input logic [15:0] r, input logic [3:0] t,
                              input logic [3:0] rd, input logic [15:0] es,
                              input logic [3:0] eg, input string name);
    vec_t v;
    v.rst_first = rf; v.req = r; v.tail = t; v.rdy = rd;
    v.sel = es; v.grant = eg; v.name = name;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs after the falling edge, then compare against the scoreboard.
  task automatic apply(input logic [15:0] r, input logic [3:0] t, input logic [3:0] rd,
                       input logic [15:0] es, input logic [3:0] eg, input string name);
    exp_t e;
    @(negedge clk);
    req = r; tail = t; out_ready = rd;
    e.sel = es; e.grant = eg; e.name = name;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.name, " select"}, 32'(select), 32'(e.sel));
    check({e.name, " grant"}, 32'(grant), 32'(e.grant));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; tail = '0; out_ready = '1;
    #1;
    check("pulse reset select", 32'(select), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int tgt[n], rem[n], waited[n], pkt_owner[n];
  bit headed[n];

  initial begin
    rst = 1'b1; req = '1; tail = '1; out_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    check("reset select", 32'(select), 32'd0);
    check("reset grant", 32'(grant), 32'd0);
    req = '0; tail = '0; rst = 1'b0;

    // Inputs 0 and 3 on output 1 right after reset: ptr=0 means input 0 wins.
    add(0, 16'h2002, 4'h0, 4'hF, 16'h0000, 4'b0000, "init_idle");
    add(0, 16'h2002, 4'h0, 4'hF, 16'h0010, 4'b0001, "init_ptr0");
    // Inputs 0,1,2 -> output 3, single-flit packets.
    add(1, 16'h0888, 4'b0111, 4'hF, 16'h0000, 4'b0000, "cont0");
    add(0, 16'h0888, 4'b0111, 4'hF, 16'h1000, 4'b0001, "cont1");
    add(0, 16'h0888, 4'b0111, 4'hF, 16'h2000, 4'b0010, "cont2");
    add(0, 16'h0888, 4'b0111, 4'hF, 16'h4000, 4'b0100, "cont3");
    add(0, 16'h0888, 4'b0111, 4'hF, 16'h1000, 4'b0001, "cont4");
    // Input 1 sends 3 flits to output 0 with a 5-cycle stall; input 2 waits.
    add(1, 16'h0110, 4'b0100, 4'hF, 16'h0000, 4'b0000, "worm_idle");
    add(0, 16'h0110, 4'b0100, 4'hF, 16'h0002, 4'b0010, "worm_f1");
    add(0, 16'h0110, 4'b0100, 4'hF, 16'h0002, 4'b0010, "worm_f2");
    for (int s = 0; s < 5; s++)
      add(0, 16'h0110, 4'b0100, 4'b1110, 16'h0002, 4'b0000, $sformatf("worm_stall%0d", s));
    add(0, 16'h0110, 4'b0110, 4'hF, 16'h0002, 4'b0010, "worm_tail");
    add(0, 16'h0100, 4'b0100, 4'hF, 16'h0004, 4'b0100, "worm_next");
    // Permutation 0->2, 1->3, 2->0, 3->1.
    add(1, 16'h2184, 4'h0, 4'hF, 16'h0000, 4'b0000, "par_idle");
    for (int s = 0; s < 3; s++)
      add(0, 16'h2184, 4'h0, 4'hF, 16'h2184, 4'b1111, $sformatf("par%0d", s));
    add(0, 16'h2184, 4'h0, 4'b0101, 16'h2184, 4'b0101, "par_partial");

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) do_reset();
      apply(vecs[k].req, vecs[k].tail, vecs[k].rdy, vecs[k].sel, vecs[k].grant, vecs[k].name);
    end

    // Reset mid-packet: move ptr[0] to 3 and lock out 0 to input 3, then reset asynchronously.
    do_reset();
    apply(16'h0100, 4'b0100, 4'hF, 16'h0000, 4'b0000, "rmp_idle");
    apply(16'h1100, 4'b0100, 4'hF, 16'h0004, 4'b0100, "rmp_in2");
    apply(16'h1000, 4'b0000, 4'hF, 16'h0008, 4'b1000, "rmp_in3");
    #2 rst = 1'b1;
    #1;
    check("rmp async select", 32'(select), 32'd0);
    check("rmp async grant", 32'(grant), 32'd0);
    req = '0; tail = '0;
    @(negedge clk);
    rst = 1'b0;
    apply(16'h1010, 4'h0, 4'hF, 16'h0000, 4'b0000, "rmp_rereq");
    apply(16'h1010, 4'h0, 4'hF, 16'h0002, 4'b0010, "rmp_ptr0");

    // Constrained random: inputs send 1..4 flit packets and hold req until the tail crosses.
    do_reset();
    for (int i = 0; i < n; i++) begin
      tgt[i] = -1; rem[i] = 0; waited[i] = 0; headed[i] = 1'b0; pkt_owner[i] = -1;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [n-1:0] exp_g;
      logic         col_ok;
      int           cnt;
      int           o;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        if (tgt[i] < 0) begin
          // A stale tail request can re-win the output; the input then owes it a packet.
          for (int oo = 0; oo < n; oo++) if (select[oo][i]) tgt[i] = oo;
          if (tgt[i] < 0 && $urandom_range(0, 2) == 0) tgt[i] = int'($urandom_range(0, n - 1));
          if (tgt[i] >= 0) begin
            rem[i] = int'($urandom_range(1, 4)); headed[i] = 1'b0; waited[i] = 0;
          end
        end
      end
      req = '0; tail = '0;
      for (int i = 0; i < n; i++) begin
        if (tgt[i] >= 0) begin
          req[i][tgt[i]] = 1'b1;
          tail[i] = (rem[i] == 1);
        end
      end
      for (int oo = 0; oo < n; oo++) out_ready[oo] = ($urandom_range(0, 3) != 0);
      #1;
      exp_g = '0;
      col_ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        cnt = 0;
        for (int oo = 0; oo < n; oo++) begin
          if (select[oo][i]) cnt++;
          if (select[oo][i] && req[i][oo] && out_ready[oo]) exp_g[i] = 1'b1;
        end
        if (cnt > 1) col_ok = 1'b0;
      end
      check($sformatf("rand grant c%0d", cyc), 32'(grant), 32'(exp_g));
      check($sformatf("rand column c%0d", cyc), 32'(col_ok), 32'd1);
      for (int i = 0; i < n; i++) begin
        if (grant[i] && tgt[i] >= 0) begin
          o = tgt[i];
          if (pkt_owner[o] < 0) begin
            check($sformatf("rand fair in%0d c%0d", i, cyc), 32'(waited[i] < n), 32'd1);
            pkt_owner[o] = i;
            headed[i] = 1'b1;
          end else begin
            check($sformatf("rand interleave out%0d c%0d", o, cyc), 32'(pkt_owner[o]), 32'(i));
          end
          rem[i]--;
          if (rem[i] == 0) begin
            pkt_owner[o] = -1;
            for (int j = 0; j < n; j++)
              if (j != i && tgt[j] == o && !headed[j]) waited[j]++;
            tgt[i] = -1;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
